// File: rtl/dram_arb_pkg.sv
// ---------------------------------------------------------------------------
// dram_arb_pkg
// Shared types and defaults for the DRAM port arbiter.
//   arb_state_t : arbiter FSM states
//   owner_t     : requester encoding (also the round-robin index)
//   DEFAULT_BURST_LEN : beats per transaction (one cache line)
//   NUM_REQ     : number of requesters feeding the round-robin pick
// ---------------------------------------------------------------------------
package dram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BURST_I   = 2'd1,
    BURST_D   = 2'd2,
    WAIT_DROP = 2'd3
  } arb_state_t;

  // The encoding doubles as the requester index into the round-robin pick.
  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  localparam int unsigned DEFAULT_BURST_LEN = 8;
  localparam int unsigned NUM_REQ           = 2;

endpackage

// File: rtl/dram_arb_rr_pick.sv
// ---------------------------------------------------------------------------
// dram_arb_rr_pick
// Combinational N-way round-robin pick. The search starts at the requester
// just after `last` and wraps, so the previous owner has the lowest priority.
//   req   : request vector, one bit per requester
//   last  : index of the previous owner
//   found : at least one request is pending
//   pick  : index of the selected requester (holds `last` when none pending)
// ---------------------------------------------------------------------------
module dram_arb_rr_pick #(
  parameter  int unsigned N     = 2,
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic             found,
  output logic [IDX_W-1:0] pick
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    found = 1'b0;
    pick  = last;
    cand  = last;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = IDX_W'((32'(last) + k) % N);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

endmodule

// File: rtl/dram_arbiter.sv
// ---------------------------------------------------------------------------
// dram_arbiter
// Shares the single DRAM port between the instruction cache (read-only line
// fills) and the data cache (fills and write-backs). One requester owns the
// port for a whole BURST_LEN-beat burst; afterwards the arbiter waits for the
// owner to drop its request before re-arbitrating.
//
// Ports:
//   CLK, RESET            clock, synchronous active-high reset
//   I_req, I_req_addr     instruction-cache fill request and line address
//   I_grant, I_data, I_valid   instruction-cache ownership and read beats
//   D_req, D_we, D_req_addr    data-cache request, direction, line address
//   D_wdata, D_wdata_pop       write-back beat and its accept strobe
//   D_grant, D_data, D_valid   data-cache ownership and read beats
//   MEM_req, MEM_we, MEM_addr, MEM_wdata   DRAM transaction side
//   MEM_rdata, MEM_valid       DRAM read data / per-beat handshake
//   err_stray             sticky: MEM_valid seen with no burst active
// ---------------------------------------------------------------------------
module dram_arbiter
  import dram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned BURST_LEN = DEFAULT_BURST_LEN
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              I_req,
  input  logic [ADDR_W-1:0] I_req_addr,
  output logic              I_grant,
  output logic [DATA_W-1:0] I_data,
  output logic              I_valid,
  input  logic              D_req,
  input  logic              D_we,
  input  logic [ADDR_W-1:0] D_req_addr,
  input  logic [DATA_W-1:0] D_wdata,
  output logic              D_wdata_pop,
  output logic              D_grant,
  output logic [DATA_W-1:0] D_data,
  output logic              D_valid,
  output logic              MEM_req,
  output logic              MEM_we,
  output logic [ADDR_W-1:0] MEM_addr,
  output logic [DATA_W-1:0] MEM_wdata,
  input  logic [DATA_W-1:0] MEM_rdata,
  input  logic              MEM_valid,
  output logic              err_stray
);

  // One extra bit so the counter never wraps before the terminal compare.
  localparam int unsigned      CNT_W     = $clog2(BURST_LEN) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  arb_state_t       state;
  logic [CNT_W-1:0] beat_cnt;
  owner_t           last_owner;

  logic             pick_found;
  logic [0:0]       pick_idx;
  owner_t           pick_owner;
  logic             owner_req;

  dram_arb_rr_pick #(
    .N (NUM_REQ)
  ) u_rr_pick (
    .req   ({D_req, I_req}),
    .last  (last_owner),
    .found (pick_found),
    .pick  (pick_idx)
  );

  assign pick_owner = owner_t'(pick_idx);

  // In WAIT_DROP last_owner already names the owner of the finished burst.
  assign owner_req = (last_owner == OWN_I) ? I_req : D_req;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      beat_cnt   <= '0;
      last_owner <= OWN_D;
      I_grant    <= 1'b0;
      D_grant    <= 1'b0;
      MEM_req    <= 1'b0;
      MEM_we     <= 1'b0;
      MEM_addr   <= '0;
      err_stray  <= 1'b0;
    end else begin
      if (MEM_valid && (state == IDLE || state == WAIT_DROP)) begin
        err_stray <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (pick_found) begin
            beat_cnt <= '0;
            MEM_req  <= 1'b1;
            if (pick_owner == OWN_I) begin
              state    <= BURST_I;
              I_grant  <= 1'b1;
              MEM_addr <= I_req_addr;
              MEM_we   <= 1'b0;
            end else begin
              state    <= BURST_D;
              D_grant  <= 1'b1;
              MEM_addr <= D_req_addr;
              MEM_we   <= D_we;
            end
          end
        end

        // The owner's request is not looked at here: a mid-burst drop is
        // ignored and the burst runs to completion.
        BURST_I, BURST_D: begin
          if (MEM_valid) begin
            if (beat_cnt == LAST_BEAT) begin
              state      <= WAIT_DROP;
              MEM_req    <= 1'b0;
              MEM_we     <= 1'b0;
              beat_cnt   <= '0;
              last_owner <= (state == BURST_I) ? OWN_I : OWN_D;
            end else begin
              beat_cnt <= beat_cnt + CNT_W'(1);
            end
          end
        end

        WAIT_DROP: begin
          if (!owner_req) begin
            state   <= IDLE;
            I_grant <= 1'b0;
            D_grant <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // Beat steering: only the current owner sees data or strobes; everything
  // is forced to zero outside a matching burst.
  logic rd_i;
  logic rd_d;
  logic wr_d;

  always_comb begin
    rd_i = (state == BURST_I);
    rd_d = (state == BURST_D) && !MEM_we;
    wr_d = (state == BURST_D) &&  MEM_we;

    I_data      = rd_i ? MEM_rdata : '0;
    I_valid     = rd_i && MEM_valid;
    D_data      = rd_d ? MEM_rdata : '0;
    D_valid     = rd_d && MEM_valid;
    MEM_wdata   = wr_d ? D_wdata : '0;
    D_wdata_pop = wr_d && MEM_valid;
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dram_arbiter
// Self-checking bench for dram_arbiter. The bench plays both caches and the
// DRAM; a transaction-level model (who wins, which address, which beats)
// supplies every expected value.
// ---------------------------------------------------------------------------
module tb_dram_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BL = 8;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          I_req;
  logic [AW-1:0] I_req_addr;
  logic          I_grant;
  logic [DW-1:0] I_data;
  logic          I_valid;
  logic          D_req;
  logic          D_we;
  logic [AW-1:0] D_req_addr;
  logic [DW-1:0] D_wdata;
  logic          D_wdata_pop;
  logic          D_grant;
  logic [DW-1:0] D_data;
  logic          D_valid;
  logic          MEM_req;
  logic          MEM_we;
  logic [AW-1:0] MEM_addr;
  logic [DW-1:0] MEM_wdata;
  logic [DW-1:0] MEM_rdata;
  logic          MEM_valid;
  logic          err_stray;

  dram_arbiter #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .BURST_LEN (BL)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .I_req       (I_req),
    .I_req_addr  (I_req_addr),
    .I_grant     (I_grant),
    .I_data      (I_data),
    .I_valid     (I_valid),
    .D_req       (D_req),
    .D_we        (D_we),
    .D_req_addr  (D_req_addr),
    .D_wdata     (D_wdata),
    .D_wdata_pop (D_wdata_pop),
    .D_grant     (D_grant),
    .D_data      (D_data),
    .D_valid     (D_valid),
    .MEM_req     (MEM_req),
    .MEM_we      (MEM_we),
    .MEM_addr    (MEM_addr),
    .MEM_wdata   (MEM_wdata),
    .MEM_rdata   (MEM_rdata),
    .MEM_valid   (MEM_valid),
    .err_stray   (err_stray)
  );

  always #5 CLK = ~CLK;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Model state: previous owner (0 = instruction cache, 1 = data cache)
  // and the expected sticky error flag.
  int   model_last;
  logic exp_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Inputs change on the falling edge; MEM_valid defaults to idle.
  task automatic tick();
    @(negedge CLK);
    MEM_valid = 1'b0;
  endtask

  task automatic apply_reset();
    tick();
    RESET = 1'b1;
    I_req = 1'b0;
    D_req = 1'b0;
    tick();
    RESET = 1'b0;
    #1;
    model_last = 1;
    exp_err    = 1'b0;
    check("rst_err", 64'(err_stray), 64'(0));
    check("rst_grants", 64'({I_grant, D_grant, MEM_req}), 64'(0));
  endtask

  // Entered one cycle after the grant edge; runs the burst, the wait for the
  // owner to drop, and the mandatory idle cycle.
  task automatic run_burst(input int who, input logic we, input logic [AW-1:0] addr,
                           input logic fixed);
    logic [DW-1:0] rd;
    logic [DW-1:0] wd;
    logic          exp_we;
    logic          stray;
    int            gaps;
    int            hold;
    exp_we = (who == 1) ? we : 1'b0;

    check("grant_i", 64'(I_grant), 64'(who == 0));
    check("grant_d", 64'(D_grant), 64'(who == 1));
    check("mem_req_on", 64'(MEM_req), 64'(1));
    check("mem_addr", 64'(MEM_addr), 64'(addr));
    check("mem_we", 64'(MEM_we), 64'(exp_we));

    for (int b = 0; b < int'(BL); b++) begin
      gaps = int'($urandom_range(0, 2));
      for (int g = 0; g < gaps; g++) begin
        tick();
        MEM_rdata = $urandom;
        D_wdata   = $urandom;
        if (who == 0) I_req_addr = $urandom;
        else begin
          D_req_addr = $urandom;
          D_we       = 1'($urandom_range(0, 1));
        end
        #1;
        check("gap_strobes", 64'({I_valid, D_valid, D_wdata_pop}), 64'(0));
        check("gap_req", 64'(MEM_req), 64'(1));
        check("gap_addr", 64'(MEM_addr), 64'(addr));
        check("gap_we", 64'(MEM_we), 64'(exp_we));
      end
      tick();
      rd = fixed ? DW'(32'hA0 + b) : DW'($urandom);
      wd = fixed ? DW'(32'h11 * (b + 1)) : DW'($urandom);
      MEM_valid = 1'b1;
      MEM_rdata = rd;
      D_wdata   = wd;
      #1;
      if (who == 0) begin
        check("i_valid", 64'(I_valid), 64'(1));
        check("i_data", 64'(I_data), 64'(rd));
        check("d_valid_off", 64'(D_valid), 64'(0));
        check("pop_off", 64'(D_wdata_pop), 64'(0));
      end else if (we) begin
        check("pop", 64'(D_wdata_pop), 64'(1));
        check("mem_wdata", 64'(MEM_wdata), 64'(wd));
        check("d_valid_wr", 64'(D_valid), 64'(0));
        check("i_valid_off", 64'(I_valid), 64'(0));
      end else begin
        check("d_valid", 64'(D_valid), 64'(1));
        check("d_data", 64'(D_data), 64'(rd));
        check("i_valid_off", 64'(I_valid), 64'(0));
        check("pop_off", 64'(D_wdata_pop), 64'(0));
      end
      check("beat_req", 64'(MEM_req), 64'(1));
      check("beat_err", 64'(err_stray), 64'(exp_err));
    end

    tick();
    #1;
    check("req_off", 64'(MEM_req), 64'(0));
    check("we_off", 64'(MEM_we), 64'(0));
    check("hold_grant", 64'((who == 0) ? I_grant : D_grant), 64'(1));

    // Owner keeps requesting for a while: no re-grant, other side waits.
    hold = int'($urandom_range(0, 2));
    for (int h = 0; h < hold; h++) begin
      tick();
      #1;
      check("wait_grant", 64'((who == 0) ? I_grant : D_grant), 64'(1));
      check("wait_other", 64'((who == 0) ? D_grant : I_grant), 64'(0));
      check("wait_req", 64'(MEM_req), 64'(0));
    end

    tick();
    if (who == 0) I_req = 1'b0;
    else D_req = 1'b0;
    #1;
    check("drop_grant", 64'((who == 0) ? I_grant : D_grant), 64'(1));

    // Idle cycle between bursts, occasionally with a stray DRAM strobe.
    tick();
    stray = ($urandom_range(0, 7) == 0);
    MEM_valid = stray;
    #1;
    check("idle_grants", 64'({I_grant, D_grant, MEM_req}), 64'(0));
    check("idle_strobes", 64'({I_valid, D_valid, D_wdata_pop}), 64'(0));
    check("idle_err", 64'(err_stray), 64'(exp_err));
    if (stray) exp_err = 1'b1;
    model_last = who;
  endtask

  task automatic do_txn(input logic ri, input logic rq, input logic we,
                        input logic [AW-1:0] ai, input logic [AW-1:0] ad,
                        input logic fixed);
    int winner;
    int loser;
    tick();
    I_req      = ri;
    D_req      = rq;
    I_req_addr = ai;
    D_req_addr = ad;
    D_we       = we;
    #1;
    check("pre_grant", 64'({I_grant, D_grant, MEM_req}), 64'(0));
    if (ri && rq) winner = (model_last == 1) ? 0 : 1;
    else winner = ri ? 0 : 1;
    tick();
    #1;
    run_burst(winner, we, (winner == 0) ? ai : ad, fixed);
    if (ri && rq) begin
      loser = 1 - winner;
      tick();
      #1;
      run_burst(loser, we, (loser == 0) ? ai : ad, fixed);
    end
  endtask

  initial begin
    int p;
    RESET      = 1'b1;
    I_req      = 1'b0;
    D_req      = 1'b0;
    D_we       = 1'b0;
    I_req_addr = 32'h1111_0000;
    D_req_addr = 32'h2222_0000;
    D_wdata    = 32'hDEAD_BEEF;
    MEM_rdata  = 32'h1234_5678;
    MEM_valid  = 1'b0;
    exp_err    = 1'b0;
    model_last = 1;

    repeat (2) @(negedge CLK);
    #1;
    check("rst_ctrl", 64'({I_grant, D_grant, MEM_req, MEM_we, err_stray}), 64'(0));
    check("rst_addr", 64'(MEM_addr), 64'(0));
    check("rst_data", 64'({I_data, D_data}), 64'(0));
    check("rst_wdata", 64'(MEM_wdata), 64'(0));
    check("rst_strobes", 64'({I_valid, D_valid, D_wdata_pop}), 64'(0));
    tick();
    RESET = 1'b0;

    // Instruction fill alone, beats 0xA0..0xA7.
    do_txn(1'b1, 1'b0, 1'b0, 32'h0000_1000, 32'h0, 1'b1);

    // Simultaneous requests straight after reset: instruction side first.
    apply_reset();
    do_txn(1'b1, 1'b1, 1'b0, 32'h0000_2000, 32'h0000_3000, 1'b0);

    // Data write-back, beats 0x11..0x88 with gaps.
    do_txn(1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_5000, 1'b1);

    // Reset on the fourth beat of an instruction burst.
    tick();
    I_req      = 1'b1;
    I_req_addr = 32'h0000_4000;
    #1;
    tick();
    #1;
    check("rm_grant", 64'(I_grant), 64'(1));
    for (int b = 0; b < 3; b++) begin
      tick();
      MEM_valid = 1'b1;
      MEM_rdata = DW'(32'hB0 + b);
      #1;
      check("rm_ivalid", 64'(I_valid), 64'(1));
    end
    tick();
    MEM_valid = 1'b1;
    MEM_rdata = 32'hB3;
    RESET     = 1'b1;
    I_req     = 1'b0;
    #1;
    check("rm_beat4", 64'(I_valid), 64'(1));
    tick();
    RESET = 1'b0;
    #1;
    check("rm_req", 64'(MEM_req), 64'(0));
    check("rm_grants", 64'({I_grant, D_grant}), 64'(0));
    model_last = 1;
    exp_err    = 1'b0;
    do_txn(1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_6000, 1'b0);

    // Random mix of single and contending requests.
    for (int n = 0; n < 40; n++) begin
      p = int'($urandom_range(1, 3));
      do_txn(p != 2, p != 1, 1'($urandom_range(0, 1)), $urandom, $urandom, 1'b0);
    end

    // Stray strobe while idle: no forwarding, sticky flag.
    tick();
    MEM_valid = 1'b1;
    #1;
    check("stray_strobes", 64'({I_valid, D_valid, D_wdata_pop}), 64'(0));
    exp_err = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      #1;
      check("stray_sticky", 64'(err_stray), 64'(exp_err));
    end
    apply_reset();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
